// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int UART_DATA_W = 8;

  // LSB position of lane idx in a packed bus of w-bit lanes
  function automatic int lane_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or above rr_ptr, wrapping.
module uart_rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         any,
  output logic [W-1:0] winner,
  output logic [N-1:0] grant
);

  logic [W:0]   sum;
  logic [W-1:0] idx;

  always_comb begin
    winner = '0;
    sum    = '0;
    idx    = '0;
    // Walk from the farthest offset down so the nearest requester is written last
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (W + 1)'(k);
      if (sum >= (W + 1)'(N)) begin
        sum = sum - (W + 1)'(N);
      end
      idx = sum[W-1:0];
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  always_comb begin
    any   = |req;
    grant = '0;
    if (any) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FSM among NUM_REQ byte sources.
// Optional watchdog on the frame is enabled with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int TIMEOUT_CYC = 200000,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      areset_n,
  input  logic                      sync_clr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic [ID_W-1:0]   grant_id_reg;
  logic              active_reg;

  logic [DATA_W-1:0] req_bytes [NUM_REQ];
  logic              pick_any;
  logic [ID_W-1:0]   pick_winner;
  logic [NUM_REQ-1:0] pick_grant;
  logic              accept;
  logic              timeout_hit;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_bytes[gi] = req_data[lane_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .any    (pick_any),
    .winner (pick_winner),
    .grant  (pick_grant)
  );

  // A clear in progress must not hand out a strobe whose byte would be dropped
  assign accept    = (state_reg == IDLE) && pick_any && !tx_busy && !sync_clr;
  assign req_ready = accept ? pick_grant : '0;
  assign tx_en     = (state_reg == LAUNCH);
  assign tx_data   = tx_data_reg;
  assign grant_id  = grant_id_reg;
  assign active    = active_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (accept) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done || timeout_hit) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      tx_data_reg  <= '0;
      grant_id_reg <= '0;
      active_reg   <= 1'b0;
    end else if (sync_clr) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      tx_data_reg  <= '0;
      grant_id_reg <= '0;
      active_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tx_data_reg  <= req_bytes[pick_winner];
        grant_id_reg <= pick_winner;
        rr_ptr_reg   <= (pick_winner == ID_W'(NUM_REQ - 1)) ? '0 : pick_winner + 1'b1;
        active_reg   <= 1'b1;
      end else if (state_reg == WAIT_DONE && state_next == IDLE) begin
        active_reg <= 1'b0;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_reg;
  logic             timeout_err_reg;

  // Count starts at the launch cycle so the flag lands TIMEOUT_CYC cycles after tx_en
  assign timeout_hit = (state_reg == WAIT_DONE) && !tx_done &&
                       (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      to_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else if (sync_clr) begin
      to_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt_reg <= '0;
      end else if (state_reg != IDLE) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
